bcd_display_decoder: RTL and testbench
======================================

BCD_DISPLAY_DECODER -- requirements
Module: bcd_display_decoder

Interface
REQ-001 Parameter SCAN_DIV, default 4, SHALL set the number of clk cycles each display digit is held (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be synchronous, active-high reset.
REQ-004 code_in  input  5  SHALL carry encoder output: bit4 = key-valid, bits[3:0] = BCD digit.
REQ-005 clr  input  1  SHALL be a synchronous active-high clear of stored digits and err.
REQ-006 seg  output  7  SHALL carry active-high segments, seg[0]=a ... seg[6]=g.
REQ-007 an  output  4  SHALL be a one-hot active-high digit enable, an[0] = rightmost digit.
REQ-008 digit_cnt  output  3  SHALL give the number of valid stored digits, 0..4.
REQ-009 err  output  1  SHALL be a sticky flag: non-BCD code captured.

Function
REQ-010 Capture FSM SHALL have states IDLE, CAPTURE and WAIT_REL.
REQ-011 IDLE -> CAPTURE SHALL occur on the first cycle code_in[4]=1.
REQ-012 The CAPTURE state SHALL last exactly one cycle and then go to WAIT_REL.
REQ-013 WAIT_REL -> IDLE SHALL occur on the first cycle code_in[4]=0; one key press SHALL store exactly one digit regardless of hold length.
REQ-014 In CAPTURE, the code_in[3:0] value sampled on the IDLE->CAPTURE edge SHALL be processed.
REQ-015 A valid digit (0..9) SHALL shift the buffer left (buf[3]<=buf[2], buf[2]<=buf[1], buf[1]<=buf[0], buf[0]<=new).
REQ-016 On a valid digit, digit_cnt SHALL increment and saturate at 4.
REQ-017 Buffer full (digit_cnt=4) plus a valid digit: the oldest digit (buf[3]) SHALL be discarded and digit_cnt SHALL remain 4.
REQ-018 Invalid digit (10..15): the buffer and digit_cnt SHALL be unchanged and err SHALL be set to 1 on the following edge.
REQ-019 Stored digits and digit_cnt SHALL be visible one cycle after the CAPTURE cycle.
REQ-020 Scan divider SHALL count 0..SCAN_DIV-1.
REQ-021 On divider wrap, scan index SHALL advance 0->1->2->3->0, so each digit is held exactly SCAN_DIV cycles.
REQ-022 an SHALL equal 1<<scan_index, combinational from registers.
REQ-023 seg SHALL decode buf[scan_index] when scan_index < digit_cnt, and SHALL be 7'h00 (blank) otherwise.
REQ-024 Decode table (hex, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-025 clr SHALL zero the buffer, digit_cnt and err on the next edge.
REQ-026 clr SHALL leave FSM state and scan counters unaffected.
REQ-027 clr asserted in the CAPTURE cycle SHALL win: the digit is dropped and err stays 0.
REQ-028 Scanning SHALL run continuously, independent of the FSM and clr.

Reset
REQ-029 While rst=1, the following SHALL be held: FSM IDLE, buffer 0, digit_cnt 0, err 0, divider 0, scan_index 0; therefore an=4'b0001, seg=7'h00.
REQ-030 rst SHALL have priority over clr and capture.
REQ-031 rst asserted during WAIT_REL with code_in[4] still 1: on release of rst, the FSM SHALL re-enter CAPTURE and store the held digit once.

Verification
REQ-032 Reset, then press 5'b1_0011 for 3 cycles and release -> digit_cnt=1, seg=4F when an=0001, seg=00 at other anodes.
REQ-033 Press 1,2,3,4,7 in sequence (each held 2+ cycles, released between) -> digit_cnt=4; an=0001/0010/0100/1000 show 07/66/4F/5B.
REQ-034 Press code 5'b1_1100 -> err=1, digit_cnt unchanged; further valid presses still store; clr -> err=0, digit_cnt=0, seg=00 on all anodes.
REQ-035 SCAN_DIV=4: each an value is held exactly 4 cycles; an sequence 0001,0010,0100,1000,0001 repeats from reset.
REQ-036 clr asserted in the CAPTURE cycle of digit 8 -> digit_cnt=0, buffer empty, err=0.
REQ-037 Hold code_in=5'b1_1001 for 20 cycles -> exactly one digit 9 stored (digit_cnt=1).

Source files
------------

// File: rtl/bcd_display_decoder.sv
// -----------------------------------------------------------------------------
// bcd_display_decoder
//
// Captures BCD key codes from a keypad encoder into a four-digit shift buffer
// and drives a multiplexed four-digit seven-segment display.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (priority over everything)
//   code_in    : [4] key-valid, [3:0] BCD digit from the encoder
//   clr        : synchronous active-high clear of stored digits and err
//   seg        : active-high segments, seg[0]=a ... seg[6]=g
//   an         : one-hot active-high digit enable, an[0] = rightmost digit
//   digit_cnt  : number of valid stored digits, 0..4
//   err        : sticky flag, set when a non-BCD code was captured
//
// Parameter:
//   SCAN_DIV   : clk cycles each digit is held on the display (1..255)
// -----------------------------------------------------------------------------
module bcd_display_decoder #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] code_in,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] digit_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    state_t     state_reg, state_next;
    logic [3:0] code_reg;
    logic [3:0] digit_reg  [4];
    logic [3:0] digit_next [4];
    logic [2:0] cnt_reg, cnt_next;
    logic       err_reg, err_next;
    logic [7:0] div_reg;
    logic [1:0] idx_reg;

    logic capture_load;
    logic code_valid;
    logic store_digit;
    logic flag_err;

    // ------------------------------------------------------------------
    // Capture FSM: one stored digit per key press, however long it is held
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (code_in[4]) state_next = CAPTURE;
            CAPTURE:  state_next = WAIT_REL;
            WAIT_REL: if (!code_in[4]) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The digit is latched on the IDLE->CAPTURE edge and processed in CAPTURE
    assign capture_load = (state_reg == IDLE) && code_in[4];
    assign code_valid   = (code_reg <= 4'd9);
    assign store_digit  = (state_reg == CAPTURE) && code_valid;
    assign flag_err     = (state_reg == CAPTURE) && !code_valid;

    // clr dominates a simultaneous capture, so the digit is simply dropped
    assign cnt_next = clr ? 3'd0 :
                      (store_digit && (cnt_reg != 3'd4)) ? cnt_reg + 3'd1 :
                      cnt_reg;
    assign err_next = clr ? 1'b0 : (err_reg | flag_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            code_reg  <= 4'd0;
            cnt_reg   <= 3'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture_load) begin
                code_reg <= code_in[3:0];
            end
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Digit buffer: newest digit enters at position 0, oldest falls off 3
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_head
                assign digit_next[gi] = clr         ? 4'd0     :
                                        store_digit ? code_reg :
                                        digit_reg[gi];
            end else begin : g_tail
                assign digit_next[gi] = clr         ? 4'd0              :
                                        store_digit ? digit_reg[gi - 1] :
                                        digit_reg[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_reg[gi] <= 4'd0;
                end else begin
                    digit_reg[gi] <= digit_next[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Display scan: free-running, untouched by the FSM and by clr
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= 8'd0;
            idx_reg <= 2'd0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= 8'd0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            div_reg <= div_reg + 8'd1;
        end
    end

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Positions at or above the digit count are blanked
    assign an        = 4'b0001 << idx_reg;
    assign seg       = ({1'b0, idx_reg} < cnt_reg) ? decode_digit(digit_reg[idx_reg]) : 7'h00;
    assign digit_cnt = cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bcd_display_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_decoder
//
// Directed self-checking bench for bcd_display_decoder (SCAN_DIV = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_bcd_display_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] code_in;
    logic       clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] digit_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    bcd_display_decoder #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .clr       (clr),
        .seg       (seg),
        .an        (an),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Watch 16 cycles of scanning and compare seg against the expected
    // pattern for whichever digit is enabled; e0 belongs to an[0].
    task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg;
        for (int c = 0; c < 16; c++) begin
            case (an)
                4'b0001: exp_seg = e0;
                4'b0010: exp_seg = e1;
                4'b0100: exp_seg = e2;
                4'b1000: exp_seg = e3;
                default: exp_seg = 7'h7F;
            endcase
            checks++;
            assert ((an == 4'b0001 || an == 4'b0010 || an == 4'b0100 || an == 4'b1000)
                    && seg === exp_seg) else begin
                errors++;
                $error("FAIL %s an=%b seg=%0h expected=%0h", tag, an, seg, exp_seg);
            end
            step();
        end
        $display("display %-12s checked 16 scan cycles", tag);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        code_in = {1'b1, code};
        repeat (hold) step();
        code_in = 5'b0_0000;
        repeat (2) step();
    endtask

    initial begin
        rst     = 1'b1;
        clr     = 1'b0;
        code_in = 5'b0_0000;
        repeat (3) step();

        // Reset state
        chk("rst_an",  32'(an), 32'h1);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Scan sequence from reset: each anode held 4 cycles
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            assert (an === (4'b0001 << ((i / 4) % 4))) else begin
                errors++;
                $error("FAIL scan_an cycle=%0d observed=%b expected=%b", i, an, 4'b0001 << ((i / 4) % 4));
            end
            step();
        end
        $display("scan sequence checked over 20 cycles");

        // Press 3 for 3 cycles, with visibility timing
        code_in = 5'b1_0011;
        step();                                   // now in CAPTURE
        chk("lat_capture", 32'(digit_cnt), 32'd0);
        step();                                   // digit now stored
        chk("lat_stored", 32'(digit_cnt), 32'd1);
        step();
        code_in = 5'b0_0000;
        repeat (2) step();
        chk("press3_cnt", 32'(digit_cnt), 32'd1);
        check_display("press3", 7'h4F, 7'h00, 7'h00, 7'h00);

        // Clear, then five presses: oldest discarded, count saturates
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_cnt", 32'(digit_cnt), 32'd0);
        press(4'd1, 2); press(4'd2, 2); press(4'd3, 2);
        press(4'd4, 3); press(4'd7, 2);
        chk("five_cnt", 32'(digit_cnt), 32'd4);
        check_display("five", 7'h07, 7'h66, 7'h4F, 7'h5B);

        // Invalid code sets err, buffer unchanged
        press(4'd12, 2);
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_cnt", 32'(digit_cnt), 32'd4);
        check_display("inv", 7'h07, 7'h66, 7'h4F, 7'h5B);

        // Valid digit still stored after err, err stays sticky
        press(4'd5, 2);
        chk("after_err", 32'(err), 32'd1);
        chk("after_cnt", 32'(digit_cnt), 32'd4);
        check_display("after", 7'h6D, 7'h07, 7'h66, 7'h4F);

        // clr wipes buffer, count and err
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_cnt", 32'(digit_cnt), 32'd0);
        check_display("clr2", 7'h00, 7'h00, 7'h00, 7'h00);

        // clr in the CAPTURE cycle of digit 8 wins
        press(4'd2, 2);
        chk("pre8_cnt", 32'(digit_cnt), 32'd1);
        code_in = 5'b1_1000;
        step();                                   // CAPTURE cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        code_in = 5'b0_0000;
        repeat (2) step();
        chk("clr8_cnt", 32'(digit_cnt), 32'd0);
        chk("clr8_err", 32'(err), 32'd0);
        check_display("clr8", 7'h00, 7'h00, 7'h00, 7'h00);

        // Long hold of 9 stores exactly one digit
        press(4'd9, 20);
        chk("hold9_cnt", 32'(digit_cnt), 32'd1);
        check_display("hold9", 7'h6F, 7'h00, 7'h00, 7'h00);

        // Reset during WAIT_REL with key held: stored once more after release
        code_in = 5'b1_0110;
        repeat (3) step();                        // captured, now WAIT_REL
        chk("held6_cnt", 32'(digit_cnt), 32'd2);
        rst = 1'b1;
        repeat (2) step();
        chk("rsthold_cnt", 32'(digit_cnt), 32'd0);
        chk("rsthold_an", 32'(an), 32'h1);
        rst = 1'b0;
        repeat (3) step();                        // IDLE -> CAPTURE -> stored
        chk("recap_cnt", 32'(digit_cnt), 32'd1);
        repeat (4) step();
        chk("recap_once", 32'(digit_cnt), 32'd1);
        code_in = 5'b0_0000;
        repeat (2) step();
        check_display("recap", 7'h7D, 7'h00, 7'h00, 7'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
